// File: rtl/ifid_inst_buffer_pkg.sv
// IF-to-ID packet layout and default buffer depth shared by the fetch/decode decoupling buffer.
package ifid_inst_buffer_pkg;

  localparam int IFID_BUS_W   = 66;
  localparam int EXCP_EN_BIT  = 65;
  localparam int EXCP_NUM_BIT = 64;
  localparam int PC_MSB       = 63;
  localparam int PC_LSB       = 32;
  localparam int INST_MSB     = 31;
  localparam int IBUF_DEPTH   = 2;

  typedef struct packed {
    logic        excp_en;
    logic        excp_num;
    logic [31:0] pc;
    logic [31:0] inst;
  } ifid_pkt_t;

endpackage

// File: rtl/ifid_ibuf_ram.sv
// DEPTH x BUS_W packet storage: one synchronous write port, asynchronous read port, no reset.
module ifid_ibuf_ram #(
  parameter int DEPTH = 2,
  parameter int BUS_W = 66,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [BUS_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [BUS_W-1:0] rdata
);

  logic [BUS_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ifid_inst_buffer.sv
// IF->ID decoupling FIFO holding fetched packets while decode stalls; flush squashes all contents.
// Latency 1 cycle (0 when IFID_IBUF_BYPASS_EN is defined and the buffer is empty with decode ready).
// Backpressure: in_ready drops only when full and never looks at out_ready; flush blocks push and pop.
module ifid_inst_buffer
  import ifid_inst_buffer_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int BUS_W = IFID_BUS_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  input  logic [BUS_W-1:0]           in_bus,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [BUS_W-1:0]           out_bus,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic [BUS_W-1:0] rd_dat;
  logic             empty, push, pop;

  assign empty    = (count == '0);
  assign in_ready = (count != FULL);

`ifdef IFID_IBUF_BYPASS_EN
  logic bypass;
  // An arriving packet is shown directly while empty; it is only stored if decode does not take it.
  assign bypass    = empty & in_valid & ~flush & resetn;
  assign out_valid = ~empty & ~flush | bypass;
  assign out_bus   = bypass ? in_bus : (out_valid ? rd_dat : '0);
  assign push      = in_valid & in_ready & ~flush & ~(bypass & out_ready);
`else
  assign out_valid = ~empty & ~flush;
  assign out_bus   = out_valid ? rd_dat : '0;
  assign push      = in_valid & in_ready & ~flush;
`endif

  assign pop       = out_valid & out_ready & ~empty;
  assign occupancy = count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  ifid_ibuf_ram #(
    .DEPTH (DEPTH),
    .BUS_W (BUS_W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_bus),
    .raddr (rd_ptr),
    .rdata (rd_dat)
  );

endmodule

// File: tb/tb_ifid_inst_buffer.sv
// Randomized and directed check of ifid_inst_buffer against a queue-based packet model.
module tb_ifid_inst_buffer;
  import ifid_inst_buffer_pkg::*;

  localparam int DEPTH = IBUF_DEPTH;
  localparam int BW    = IFID_BUS_W;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          resetn;
  logic          in_valid;
  logic [BW-1:0] in_bus;
  logic          in_ready;
  logic          out_valid;
  logic [BW-1:0] out_bus;
  logic          out_ready;
  logic          flush;
  logic [CW-1:0] occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [BW-1:0] q[$];

  ifid_inst_buffer #(.DEPTH(DEPTH), .BUS_W(BW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_bus    (in_bus),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bus   (out_bus),
    .out_ready (out_ready),
    .flush     (flush),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] mk(input logic en, input logic num,
                                       input logic [31:0] pc, input logic [31:0] inst);
    ifid_pkt_t p;
    p.excp_en  = en;
    p.excp_num = num;
    p.pc       = pc;
    p.inst     = inst;
    return p;
  endfunction

  task automatic drive(input logic v, input logic [BW-1:0] b, input logic r, input logic f);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_bus    = b;
    out_ready = r;
    flush     = f;
  endtask

  // Reference model: the buffer is an ordered list of at most DEPTH packets.
  always @(negedge resetn) q.delete();

  always @(posedge clk) begin
    if (!resetn || flush) begin
      q.delete();
    end else begin
      bit byp, pop_m, push_m;
      byp = 1'b0;
`ifdef IFID_IBUF_BYPASS_EN
      byp = (q.size() == 0) && in_valid && out_ready;
`endif
      pop_m  = (q.size() != 0) && out_ready;
      push_m = in_valid && (q.size() < DEPTH) && !byp;
      if (pop_m)  void'(q.pop_front());
      if (push_m) q.push_back(in_bus);
    end
  end

  always @(negedge clk) begin
    logic          ev;
    logic [BW-1:0] eb;
    ev = (q.size() != 0) && !flush;
    eb = ev ? q[0] : '0;
`ifdef IFID_IBUF_BYPASS_EN
    if ((q.size() == 0) && in_valid && !flush && resetn) begin
      ev = 1'b1;
      eb = in_bus;
    end
`endif
    chk("model_out_valid", BW'(out_valid), BW'(ev));
    chk("model_out_bus",   out_bus, eb);
    chk("model_in_ready",  BW'(in_ready), BW'(q.size() != DEPTH));
    chk("model_occupancy", BW'(occupancy), BW'(q.size()));
  end

  logic [BW-1:0] x0;
  logic [95:0]   rnd;

  initial begin
    x0        = '0;
    resetn    = 1'b0;
    in_valid  = 1'b1;
    in_bus    = mk(1'b0, 1'b0, 32'h1c00_0040, 32'h0280_0c0c);
    out_ready = 1'b1;
    flush     = 1'b0;

    // Reset with in_valid held high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", BW'(out_valid), BW'(0));
    chk("rst_in_ready",  BW'(in_ready),  BW'(1));
    chk("rst_occupancy", BW'(occupancy), BW'(0));
    chk("rst_out_bus",   out_bus,        BW'(0));
    @(posedge clk);
    #1;
    resetn   = 1'b1;
    in_valid = 1'b0;

    drive(1'b1, mk(1'b0, 1'b0, 32'h1c00_0000, 32'h0280_0c0c), 1'b0, 1'b0);
    drive(1'b0, x0, 1'b1, 1'b0);
    @(negedge clk);
    chk("first_out_valid", BW'(out_valid),   BW'(1));
    chk("first_pc",        BW'(out_bus[PC_MSB:PC_LSB]), BW'(32'h1c00_0000));
    chk("first_inst",      BW'(out_bus[INST_MSB:0]),    BW'(32'h0280_0c0c));

    // Stall fill
    drive(1'b1, mk(1'b0, 1'b0, 32'h1c00_0000, 32'h1), 1'b0, 1'b0);
    drive(1'b1, mk(1'b0, 1'b0, 32'h1c00_0004, 32'h2), 1'b0, 1'b0);
    drive(1'b1, mk(1'b0, 1'b0, 32'h1c00_0008, 32'h3), 1'b0, 1'b0);
    @(negedge clk);
    chk("fill_occupancy", BW'(occupancy), BW'(2));
    chk("fill_in_ready",  BW'(in_ready),  BW'(0));
    drive(1'b0, x0, 1'b1, 1'b0);
    @(negedge clk);
    chk("drain0_pc", BW'(out_bus[PC_MSB:PC_LSB]), BW'(32'h1c00_0000));
    drive(1'b0, x0, 1'b1, 1'b0);
    @(negedge clk);
    chk("drain1_pc", BW'(out_bus[PC_MSB:PC_LSB]), BW'(32'h1c00_0004));
    drive(1'b0, x0, 1'b1, 1'b0);
    @(negedge clk);
    chk("drain_empty", BW'(out_valid), BW'(0));

    // Streaming with pointer wrap
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, mk(1'b0, 1'b0, 32'h1c00_1000 + 32'(4 * i), 32'(i)), 1'b1, 1'b0);
      @(negedge clk);
`ifndef IFID_IBUF_BYPASS_EN
      if (i > 0) begin
        chk("stream_occupancy", BW'(occupancy), BW'(1));
        chk("stream_in_ready",  BW'(in_ready),  BW'(1));
        chk("stream_pc", BW'(out_bus[PC_MSB:PC_LSB]), BW'(32'h1c00_1000 + 32'(4 * (i - 1))));
      end
`endif
    end
    drive(1'b0, x0, 1'b1, 1'b0);

    // Flush while full, with push and pop requested
    drive(1'b1, mk(1'b0, 1'b0, 32'h1c00_0010, 32'h4), 1'b0, 1'b0);
    drive(1'b1, mk(1'b0, 1'b0, 32'h1c00_0014, 32'h5), 1'b0, 1'b0);
    drive(1'b1, mk(1'b0, 1'b0, 32'h1c00_0018, 32'h6), 1'b1, 1'b1);
    @(negedge clk);
    chk("flush_out_valid", BW'(out_valid), BW'(0));
    chk("flush_out_bus",   out_bus,        BW'(0));
    drive(1'b0, x0, 1'b1, 1'b0);
    @(negedge clk);
    chk("flush_occupancy", BW'(occupancy), BW'(0));
    drive(1'b1, mk(1'b0, 1'b0, 32'h1c00_0100, 32'h7), 1'b0, 1'b0);
    drive(1'b0, x0, 1'b1, 1'b0);
    @(negedge clk);
    chk("post_flush_pc", BW'(out_bus[PC_MSB:PC_LSB]), BW'(32'h1c00_0100));

    // Exception bits pass through
    drive(1'b1, mk(1'b1, 1'b1, 32'h1c00_0002, 32'h0), 1'b0, 1'b0);
    drive(1'b0, x0, 1'b1, 1'b0);
    @(negedge clk);
    chk("excp_bits", BW'(out_bus[EXCP_EN_BIT:EXCP_NUM_BIT]), BW'(2'b11));
    chk("excp_pc",   BW'(out_bus[PC_MSB:PC_LSB]),            BW'(32'h1c00_0002));
    drive(1'b0, x0, 1'b0, 1'b0);

`ifdef IFID_IBUF_BYPASS_EN
    drive(1'b1, mk(1'b0, 1'b0, 32'h1c00_0008, 32'h8), 1'b1, 1'b0);
    @(negedge clk);
    chk("byp_out_valid", BW'(out_valid), BW'(1));
    chk("byp_pc",        BW'(out_bus[PC_MSB:PC_LSB]), BW'(32'h1c00_0008));
    chk("byp_occupancy", BW'(occupancy), BW'(0));
    drive(1'b0, x0, 1'b0, 1'b0);
    @(negedge clk);
    chk("byp_not_stored", BW'(occupancy), BW'(0));
    drive(1'b1, mk(1'b0, 1'b0, 32'h1c00_0008, 32'h8), 1'b0, 1'b0);
    drive(1'b0, x0, 1'b0, 1'b0);
    @(negedge clk);
    chk("byp_stall_stored", BW'(occupancy), BW'(1));
    drive(1'b0, x0, 1'b1, 1'b0);
`endif

    // Random traffic with flushes and occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rnd       = {$urandom, $urandom, $urandom};
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bus    = rnd[BW-1:0];
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 15) == 0);
      if (!resetn) begin
        resetn = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        #2;
        resetn = 1'b0;
      end
    end
    drive(1'b0, x0, 1'b1, 1'b0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifid_inst_buffer.md
Name: ifid_inst_buffer

Overview:
- Decoupling FIFO between the instruction-fetch stage and the decode stage of the LoongArch 5-stage pipeline.
- Captures each fetched packet {excp_en, excp_num, pc, inst} when it arrives with IF_to_ID_Valid, so the synchronous SRAM read data is not lost while decode stalls.
- Presents packets to decode in order with a valid/ready handshake.
- Flushed on branch redirect, exception or ertn.

Parameters:
- DEPTH, 2, number of packet entries; power of two, at least 2.
- BUS_W, 66, packet width: excp_en[65], excp_num[64], pc[63:32], inst[31:0].

Ports:
- clk  in  1  pipeline clock.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  IF packet valid (IF_to_ID_Valid).
- in_bus  in  BUS_W  IF packet (IF_to_ID_Bus).
- in_ready  out  1  buffer can accept a packet this cycle.
- out_valid  out  1  packet presented to decode.
- out_bus  out  BUS_W  oldest packet.
- out_ready  in  1  decode accepts the packet (ID allow-in).
- flush  in  1  discard all contents (br_taken | excp_flush | ertn_flush).
- occupancy  out  $clog2(DEPTH+1)  current entry count.

Behaviour:
- Storage: DEPTH x BUS_W register array, rd_ptr/wr_ptr of $clog2(DEPTH) bits, plus count. Pointers wrap modulo DEPTH. Storage itself is not reset.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready.
- Asynchronous reset (resetn low): pointers 0, count 0, out_valid 0, in_ready 1, out_bus 0, occupancy 0. Reset takes effect immediately mid-operation; any pending packet is lost.
- in_ready = (count != DEPTH). It depends only on registered state, never on out_ready; there is no pass-through when full.
- out_valid = (count != 0) & ~flush. out_bus = entry[rd_ptr] when out_valid, else 0.
- Latency: 1 cycle. A packet pushed in cycle N is visible on out_bus in cycle N+1.
- Push only: write entry[wr_ptr], wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop in the same cycle: both pointers advance, count unchanged. Legal at any count 1..DEPTH-1.
- Full (count == DEPTH): in_ready 0; in_valid is ignored.
- Empty: out_valid 0; out_ready is ignored.
- flush high: push and pop are suppressed that cycle. At the next edge count, rd_ptr and wr_ptr all return to 0. out_valid is forced 0 combinationally during the flush cycle, so decode never latches a squashed packet.
- flush has priority over every other event, including a simultaneous push, pop, or full condition.
- Exception bits travel untouched. The buffer never interprets excp_en or excp_num.
- occupancy = count, registered.

Optional Feature:
- Macro: IFID_IBUF_BYPASS_EN.
- Defined: when count == 0, in_valid=1, flush=0 and out_ready=1, the packet passes combinationally to out_bus in the same cycle.
  - out_valid = (count != 0 | in_valid) & ~flush.
  - The packet is not written; pointers and count are unchanged.
  - When empty with out_ready=0, the packet is written normally.
- Undefined: strict 1-cycle latency as described above.
- in_ready is identical in both builds.

Decomposition:
- Shared package/header (alongside the existing bus-size defines) holds:
  - the IF-to-ID bus width and field offsets (EXCP_EN_BIT=65, EXCP_NUM_BIT=64, PC_MSB=63, PC_LSB=32, INST_MSB=31);
  - the default buffer depth.
- One natural sub-module: ifid_ibuf_ram, the DEPTH x BUS_W register array with a single write port and an asynchronous read port.
- Pointer, count and flush logic stay in the top module.

Test Plan:
1. Reset: hold resetn=0 for 3 cycles with in_valid=1 -> out_valid=0, in_ready=1, occupancy=0, out_bus=0. Release; push pc=0x1c000000, inst=0x02800c0c -> out_valid=1 next cycle with out_bus[63:32]=0x1c000000.
2. Stall fill: out_ready=0; push pc 0x1c000000 and 0x1c000004 -> occupancy=2, in_ready=0. A third in_valid is ignored. Raise out_ready -> packets drain in order 0x1c000000 then 0x1c000004, then out_valid=0.
3. Streaming: out_ready=1 with a push every cycle for 8 packets -> occupancy stays 1, in_ready stays 1, no drop or reorder, pointers wrap correctly past DEPTH.
4. Flush: occupancy=2; assert flush together with in_valid and out_ready -> out_valid=0 that cycle, occupancy=0 next cycle. The next push pc=0x1c000100 is the first packet out.
5. Exception passthrough: push excp_en=1, excp_num=1, pc=0x1c000002 -> out_bus[65:64]=2'b11 and the pc is unchanged.
6. Bypass build (IFID_IBUF_BYPASS_EN): with empty buffer and out_ready=1, push pc=0x1c000008 -> out_valid=1 in the same cycle and occupancy remains 0. With out_ready=0, the same push gives occupancy=1.
